// File: rtl/vram_dma_pkg.sv
// Shared definitions for the VRAM DMA engine: FSM states, register map,
// CTRL/STATUS bit positions and the LEN-to-byte-count conversion.
package vram_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    REQ     = 3'd2,
    READ    = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [15:0] DEF_VRAM_BASE = 16'h4000;

  // Register indices within the DMA window
  localparam logic [2:0] REG_SRC_LO = 3'd0;
  localparam logic [2:0] REG_SRC_HI = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_LEN    = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;

  // CTRL write bits
  localparam int CTRL_START   = 0;
  localparam int CTRL_WAIT_VB = 1;
  localparam int CTRL_ABORT   = 6;
  localparam int CTRL_CLR_IRQ = 7;

  // STATUS read bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_WAITING = 1;
  localparam int STAT_IRQ     = 7;

  // LEN of zero encodes a full 256-byte block
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/vram_dma_if.sv
// Shared-bus connection between the DMA engine (master) and the
// arbiter / memory side (slave).
interface vram_dma_if;
  logic        bus_req;
  logic        bus_grant;
  logic [15:0] dma_address;
  logic [7:0]  dma_read_data;
  logic [7:0]  dma_write_data;
  logic        dma_write_enable;

  modport master (
    output bus_req, dma_address, dma_write_data, dma_write_enable,
    input  bus_grant, dma_read_data
  );

  modport slave (
    input  bus_req, dma_address, dma_write_data, dma_write_enable,
    output bus_grant, dma_read_data
  );
endinterface

// File: rtl/vram_dma_regs.sv
// CPU-visible register file of the DMA engine plus the read mux.
// Configuration is frozen while a transfer is in flight; CTRL still
// delivers abort and clr_irq pulses at any time.
module vram_dma_regs
  import vram_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_i,
  input  logic [2:0]  addr_i,
  input  logic [7:0]  wdata_i,
  input  logic        we_i,
  input  logic        busy_i,
  input  logic        waiting_i,
  input  logic        irq_i,
  output logic [7:0]  rdata_o,
  output logic [15:0] src_o,
  output logic [11:0] dst_o,
  output logic [7:0]  len_o,
  output logic        wait_vb_o,
  output logic        start_o,
  output logic        start_vb_o,
  output logic        abort_o,
  output logic        clr_irq_o
);

  logic [7:0] src_lo_q, src_hi_q, dst_lo_q, len_q;
  logic [3:0] dst_hi_q;
  logic       wait_vb_q;
  logic       wr, ctrl_wr, cfg_wr;

  assign wr      = sel_i & we_i;
  assign ctrl_wr = wr && (addr_i == REG_CTRL);
  assign cfg_wr  = wr & ~busy_i;

  // Start is only honoured from idle; the vblank mode travels with it so
  // the FSM sees the value written in the same CTRL access.
  assign start_o    = ctrl_wr & ~busy_i & wdata_i[CTRL_START];
  assign start_vb_o = wdata_i[CTRL_WAIT_VB];
  assign abort_o    = ctrl_wr & wdata_i[CTRL_ABORT];
  assign clr_irq_o  = ctrl_wr & wdata_i[CTRL_CLR_IRQ];

  assign src_o     = {src_hi_q, src_lo_q};
  assign dst_o     = {dst_hi_q, dst_lo_q};
  assign len_o     = len_q;
  assign wait_vb_o = wait_vb_q;

  // Configuration registers, writable only while the engine is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_lo_q  <= 8'h00;
      src_hi_q  <= 8'h00;
      dst_lo_q  <= 8'h00;
      dst_hi_q  <= 4'h0;
      len_q     <= 8'h00;
      wait_vb_q <= 1'b0;
    end else if (cfg_wr) begin
      case (addr_i)
        REG_SRC_LO: src_lo_q  <= wdata_i;
        REG_SRC_HI: src_hi_q  <= wdata_i;
        REG_DST_LO: dst_lo_q  <= wdata_i;
        REG_DST_HI: dst_hi_q  <= wdata_i[3:0];
        REG_LEN:    len_q     <= wdata_i;
        REG_CTRL:   wait_vb_q <= wdata_i[CTRL_WAIT_VB];
        default:    ;
      endcase
    end
  end

  // Read mux; unselected or unmapped reads return zero
  always_comb begin
    rdata_o = 8'h00;
    if (sel_i) begin
      case (addr_i)
        REG_SRC_LO: rdata_o = src_lo_q;
        REG_SRC_HI: rdata_o = src_hi_q;
        REG_DST_LO: rdata_o = dst_lo_q;
        REG_DST_HI: rdata_o = {4'h0, dst_hi_q};
        REG_LEN:    rdata_o = len_q;
        REG_CTRL: begin
          rdata_o[STAT_IRQ]     = irq_i;
          rdata_o[STAT_WAITING] = waiting_i;
          rdata_o[STAT_BUSY]    = busy_i;
        end
        default:    rdata_o = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/vram_dma_controller.sv
// DMA engine copying a CPU-space byte block into VRAM over the shared bus.
// One byte takes a READ cycle (source address out, data latched at the end)
// followed by a WRITE cycle (VRAM address, data and strobe out).
module vram_dma_controller
  import vram_dma_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = DEF_VRAM_BASE,
  parameter int          VRAM_AW   = 12
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        SELECT_dma,
  input  logic [2:0]  reg_addr,
  input  logic [7:0]  data_in,
  input  logic        write_enable,
  output logic [7:0]  data_out,
  input  logic        in_vblank,
  output logic        dma_irq,
  vram_dma_if.master  bus
);

  localparam logic [VRAM_AW-1:0] DST_ONE = {{(VRAM_AW-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [15:0]        src_q, src_d, addr_q;
  logic [VRAM_AW-1:0] dst_q, dst_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [7:0]         byte_q;
  logic               req_q, we_q, irq_q;

  logic [15:0] cfg_src;
  logic [11:0] cfg_dst;
  logic [7:0]  cfg_len;
  logic        cfg_wait_vb, start_p, start_vb, abort_p, clr_p;
  logic        busy, waiting;

  assign busy    = (state_q != IDLE);
  assign waiting = (state_q == WAIT_VB);

  assign src_d = src_q + 16'd1;
  assign dst_d = dst_q + DST_ONE;
  assign cnt_d = cnt_q - 9'd1;

  vram_dma_regs u_regs (
    .clk        (cpu_clk),
    .rst        (rst),
    .sel_i      (SELECT_dma),
    .addr_i     (reg_addr),
    .wdata_i    (data_in),
    .we_i       (write_enable),
    .busy_i     (busy),
    .waiting_i  (waiting),
    .irq_i      (irq_q),
    .rdata_o    (data_out),
    .src_o      (cfg_src),
    .dst_o      (cfg_dst),
    .len_o      (cfg_len),
    .wait_vb_o  (cfg_wait_vb),
    .start_o    (start_p),
    .start_vb_o (start_vb),
    .abort_o    (abort_p),
    .clr_irq_o  (clr_p)
  );

  // An abort arriving during WRITE must kill the strobe already on the bus
  assign bus.dma_write_enable = we_q & ~abort_p;
  assign bus.bus_req          = req_q;
  assign bus.dma_address      = addr_q;
  assign bus.dma_write_data   = byte_q;
  assign dma_irq              = irq_q;

  // Transfer FSM with address/count progress, byte latch and registered bus outputs
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= 16'h0000;
      dst_q   <= '0;
      cnt_q   <= 9'd0;
      byte_q  <= 8'h00;
      addr_q  <= 16'h0000;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      // Completion outranks a simultaneous clear; an aborted DONE raises nothing
      if (state_q == DONE && !abort_p) irq_q <= 1'b1;
      else if (clr_p)                  irq_q <= 1'b0;

      if (abort_p) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= 16'h0000;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_p) begin
              src_q <= cfg_src;
              dst_q <= cfg_dst[VRAM_AW-1:0];
              cnt_q <= len_to_count(cfg_len);
              if (start_vb) begin
                state_q <= WAIT_VB;
              end else begin
                state_q <= REQ;
                req_q   <= 1'b1;
              end
            end
          end
          WAIT_VB: begin
            if (in_vblank) begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
          REQ: begin
            if (bus.bus_grant) begin
              state_q <= READ;
              addr_q  <= src_q;
            end
          end
          READ: begin
            // Losing the bus mid-read discards the byte; it is fetched again
            if (!bus.bus_grant) begin
              state_q <= REQ;
              addr_q  <= 16'h0000;
            end else begin
              byte_q  <= bus.dma_read_data;
              state_q <= WRITE;
              we_q    <= 1'b1;
              addr_q  <= VRAM_BASE + 16'(dst_q);
            end
          end
          WRITE: begin
            // The write is committed; only the follow-on state depends on bus/vblank
            we_q  <= 1'b0;
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
            if (cnt_q == 9'd1) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              addr_q  <= 16'h0000;
            end else if (cfg_wait_vb && !in_vblank) begin
              state_q <= WAIT_VB;
              req_q   <= 1'b0;
              addr_q  <= 16'h0000;
            end else if (!bus.bus_grant) begin
              state_q <= REQ;
              addr_q  <= 16'h0000;
            end else begin
              state_q <= READ;
              addr_q  <= src_d;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_dma_controller.sv
// Directed bench for vram_dma_controller. A byte-level model derives the
// expected VRAM write stream (address, data) from SRC/DST/LEN and the source
// memory image; a compare process checks every strobed write against it.
module tb_vram_dma_controller;
  import vram_dma_pkg::*;

  logic       cpu_clk = 1'b0;
  logic       rst;
  logic       SELECT_dma;
  logic [2:0] reg_addr;
  logic [7:0] data_in;
  logic       write_enable;
  logic [7:0] data_out;
  logic       in_vblank;
  logic       dma_irq;
  logic       grant;

  logic [7:0] mem [65536];

  vram_dma_if bus();
  assign bus.bus_grant     = grant;
  assign bus.dma_read_data = mem[bus.dma_address];

  vram_dma_controller dut (
    .cpu_clk      (cpu_clk),
    .rst          (rst),
    .SELECT_dma   (SELECT_dma),
    .reg_addr     (reg_addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out),
    .in_vblank    (in_vblank),
    .dma_irq      (dma_irq),
    .bus          (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nwrites = 0;
  int irq_rises = 0;
  bit no_req_chk = 1'b0;
  logic [23:0] exp_q[$];
  int wcyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: byte i of a copy lands at VRAM_BASE + ((dst+i) mod 4096) holding mem[(src+i) mod 65536]
  task automatic expect_copy(input logic [15:0] src, input logic [11:0] dst, input logic [7:0] len);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa, da;
      sa = src + 16'(i);
      da = 16'h4000 + 16'((int'(dst) + i) % 4096);
      exp_q.push_back({da, mem[sa]});
    end
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    SELECT_dma = 1'b1; reg_addr = a; data_in = d; write_enable = 1'b1;
    @(posedge cpu_clk); #2;
    SELECT_dma = 1'b0; write_enable = 1'b0; data_in = 8'h00;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
    SELECT_dma = 1'b1; reg_addr = a;
    #1 d = data_out;
    SELECT_dma = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] a, input logic [7:0] req);
    logic [7:0] d;
    cpu_rd(a, d);
    chk(name, d, req);
  endtask

  task automatic program_xfer(input logic [15:0] src, input logic [11:0] dst, input logic [7:0] len);
    cpu_wr(REG_SRC_LO, src[7:0]);
    cpu_wr(REG_SRC_HI, src[15:8]);
    cpu_wr(REG_DST_LO, dst[7:0]);
    cpu_wr(REG_DST_HI, {4'h0, dst[11:8]});
    cpu_wr(REG_LEN, len);
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (nwrites < target && k < budget) begin
      @(posedge cpu_clk);
      k++;
    end
    if (nwrites < target) chk({name, "_timeout"}, nwrites, target);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge cpu_clk);
    #2;
  endtask

  initial forever begin
    @(posedge cpu_clk);
    cyc++;
  end

  // Compare process: every strobed write must match the head of the model stream
  initial begin : compare
    logic [23:0] e;
    logic irq_prev;
    irq_prev = 1'b0;
    forever begin
      @(negedge cpu_clk);
      if (rst === 1'b0) begin
        if (bus.dma_write_enable === 1'b1) begin
          nwrites++;
          wcyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: actual addr=%h data=%h required=no write",
                     bus.dma_address, bus.dma_write_data);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", bus.dma_address, e[23:8]);
            chk("write_data", bus.dma_write_data, e[7:0]);
          end
        end
        if (no_req_chk) chk("bus_req_low", bus.bus_req, 1'b0);
        if (dma_irq && !irq_prev) irq_rises++;
        irq_prev = dma_irq;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, c0, irq_base;
    rst = 1'b1; SELECT_dma = 1'b0; reg_addr = 3'd0; data_in = 8'h00;
    write_enable = 1'b0; in_vblank = 1'b0; grant = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) + 8'(i >> 8) + 8'h11;

    // Reset state
    #12;
    chk("rst_bus_req", bus.bus_req, 1'b0);
    chk("rst_we", bus.dma_write_enable, 1'b0);
    chk("rst_addr", bus.dma_address, 16'h0000);
    chk("rst_irq", dma_irq, 1'b0);
    rst = 1'b0;
    @(posedge cpu_clk); #2;
    for (int r = 0; r < 8; r++) chk_reg($sformatf("rst_reg%0d", r), 3'(r), 8'h00);
    cpu_wr(3'd6, 8'hFF);
    chk_reg("reg6_ignored", 3'd6, 8'h00);

    // Basic 4-byte copy, grant held high
    program_xfer(16'h0200, 12'h800, 8'd4);
    expect_copy(16'h0200, 12'h800, 8'd4);
    chk("model_pin_first", exp_q[0], {16'h4800, 8'h13});
    chk("model_pin_last", exp_q[3], {16'h4803, 8'h16});
    base = nwrites;
    wcyc.delete();
    cpu_wr(REG_CTRL, 8'h01);
    c0 = cyc;
    cpu_wr(REG_SRC_LO, 8'hAA);
    wait_writes(base + 4, 40, "basic");
    idle_cycles(3);
    chk("basic_count", nwrites - base, 4);
    if (wcyc.size() == 4) begin
      chk("first_write_latency", wcyc[0] - c0, 2);
      for (int i = 1; i < 4; i++) chk("write_spacing", wcyc[i] - wcyc[i-1], 2);
    end else chk("basic_wcyc_size", wcyc.size(), 4);
    chk("basic_drained", exp_q.size(), 0);
    chk_reg("basic_status", REG_CTRL, 8'h80);
    chk_reg("busy_write_ignored", REG_SRC_LO, 8'h00);

    // LEN=0 with wait_vblank: nothing until vblank, then 256 bytes and one irq
    program_xfer(16'h1000, 12'h000, 8'd0);
    in_vblank = 1'b0;
    irq_base = irq_rises;
    cpu_wr(REG_CTRL, 8'h83);
    no_req_chk = 1'b1;
    idle_cycles(10);
    no_req_chk = 1'b0;
    chk_reg("vb_hold_status", REG_CTRL, 8'h03);
    expect_copy(16'h1000, 12'h000, 8'd0);
    chk("model_pin_256", exp_q.size(), 256);
    chk("model_pin_255", exp_q[255], {16'h40FF, 8'h20});
    base = nwrites;
    in_vblank = 1'b1;
    wait_writes(base + 256, 700, "len256");
    idle_cycles(3);
    chk("len256_count", nwrites - base, 256);
    chk("len256_irq_once", irq_rises - irq_base, 1);
    chk_reg("len256_status", REG_CTRL, 8'h80);

    // Source and destination wrap
    program_xfer(16'hFFFF, 12'hFFE, 8'd4);
    expect_copy(16'hFFFF, 12'hFFE, 8'd4);
    chk("model_wrap0", exp_q[0], {16'h4FFE, 8'h0F});
    chk("model_wrap1", exp_q[1], {16'h4FFF, 8'h11});
    chk("model_wrap2", exp_q[2], {16'h4000, 8'h12});
    chk("model_wrap3", exp_q[3], {16'h4001, 8'h13});
    base = nwrites;
    cpu_wr(REG_CTRL, 8'h81);
    wait_writes(base + 4, 40, "wrap");
    idle_cycles(3);
    chk("wrap_count", nwrites - base, 4);
    chk("wrap_drained", exp_q.size(), 0);

    // Grant dropped during READ of byte 2
    program_xfer(16'h0300, 12'h010, 8'd6);
    expect_copy(16'h0300, 12'h010, 8'd6);
    base = nwrites;
    cpu_wr(REG_CTRL, 8'h01);
    wait_writes(base + 2, 40, "grant");
    #2 grant = 1'b0;
    #1 chk("grant_read_addr", bus.dma_address, 16'h0302);
    idle_cycles(3);
    chk("grant_hold_writes", nwrites - base, 2);
    chk("grant_hold_req", bus.bus_req, 1'b1);
    grant = 1'b1;
    wait_writes(base + 6, 60, "grant");
    idle_cycles(3);
    chk("grant_count", nwrites - base, 6);
    chk("grant_drained", exp_q.size(), 0);

    // Vblank ends after byte 10 of 20
    in_vblank = 1'b1;
    program_xfer(16'h0400, 12'h100, 8'd20);
    expect_copy(16'h0400, 12'h100, 8'd20);
    base = nwrites;
    cpu_wr(REG_CTRL, 8'h83);
    wait_writes(base + 9, 60, "vbend");
    #2 in_vblank = 1'b0;
    idle_cycles(4);
    chk("vbend_paused_count", nwrites - base, 10);
    no_req_chk = 1'b1;
    idle_cycles(6);
    no_req_chk = 1'b0;
    chk("vbend_still_paused", nwrites - base, 10);
    chk_reg("vbend_status", REG_CTRL, 8'h03);
    in_vblank = 1'b1;
    wait_writes(base + 20, 80, "vbend");
    idle_cycles(3);
    chk("vbend_count", nwrites - base, 20);
    chk("vbend_drained", exp_q.size(), 0);
    chk_reg("vbend_done_status", REG_CTRL, 8'h80);

    // Abort landing in a WRITE cycle, then start+abort together
    cpu_wr(REG_CTRL, 8'h80);
    program_xfer(16'h0500, 12'h200, 8'd8);
    expect_copy(16'h0500, 12'h200, 8'd8);
    base = nwrites;
    cpu_wr(REG_CTRL, 8'h01);
    wait_writes(base + 3, 40, "abort");
    @(posedge cpu_clk); #2;
    exp_q.delete();
    cpu_wr(REG_CTRL, 8'h40);
    no_req_chk = 1'b1;
    idle_cycles(12);
    chk("abort_writes", nwrites - base, 3);
    chk("abort_irq", dma_irq, 1'b0);
    chk_reg("abort_status", REG_CTRL, 8'h00);
    cpu_wr(REG_CTRL, 8'h41);
    idle_cycles(6);
    no_req_chk = 1'b0;
    chk("start_abort_writes", nwrites - base, 3);
    chk_reg("start_abort_status", REG_CTRL, 8'h00);

    // Asynchronous reset mid-copy
    program_xfer(16'h0600, 12'h300, 8'd8);
    expect_copy(16'h0600, 12'h300, 8'd8);
    base = nwrites;
    cpu_wr(REG_CTRL, 8'h01);
    wait_writes(base + 2, 40, "arst");
    #3 rst = 1'b1;
    #1;
    chk("arst_bus_req", bus.bus_req, 1'b0);
    chk("arst_we", bus.dma_write_enable, 1'b0);
    exp_q.delete();
    chk_reg("arst_status_in_rst", REG_CTRL, 8'h00);
    chk_reg("arst_src_hi_cleared", REG_SRC_HI, 8'h00);
    #3 rst = 1'b0;
    @(posedge cpu_clk); #2;
    no_req_chk = 1'b1;
    idle_cycles(10);
    no_req_chk = 1'b0;
    chk("arst_writes", nwrites - base, 2);
    chk("arst_irq", dma_irq, 1'b0);
    chk_reg("arst_status", REG_CTRL, 8'h00);

    // clr_irq in the completion cycle leaves irq set; a later clear drops it
    program_xfer(16'h0700, 12'h400, 8'd1);
    expect_copy(16'h0700, 12'h400, 8'd1);
    base = nwrites;
    cpu_wr(REG_CTRL, 8'h01);
    wait_writes(base + 1, 20, "clr");
    #2;
    cpu_wr(REG_CTRL, 8'h80);
    chk("clr_race_irq", dma_irq, 1'b1);
    chk_reg("clr_race_status", REG_CTRL, 8'h80);
    cpu_wr(REG_CTRL, 8'h80);
    chk("clr_idle_irq", dma_irq, 1'b0);
    chk("clr_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
